// File: rtl/dest_ip_tbl_pkg.sv
// Shared register map, command/status bit positions and FSM encoding for the
// destination-IP table access controller.
package dest_ip_tbl_pkg;

   localparam logic [2:0] REG_IDX    = 3'd0;
   localparam logic [2:0] REG_WDATA  = 3'd1;
   localparam logic [2:0] REG_RDATA  = 3'd2;
   localparam logic [2:0] REG_CMD    = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;
   localparam logic [2:0] REG_HITS   = 3'd5;

   localparam int CMD_WR_BIT    = 0;
   localparam int CMD_RD_BIT    = 1;
   localparam int STAT_BUSY_BIT = 0;
   localparam int STAT_DONE_BIT = 1;
   localparam int STAT_ERR_BIT  = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_WAIT = 3'd2,
      RD_REQ  = 3'd3,
      RD_WAIT = 3'd4
   } tbl_state_e;

endpackage

// File: rtl/dest_ip_tbl_axil_regs.sv
// AXI4-Lite slave front end: channel handshakes, IDX/WDATA registers, read mux
// and single-cycle command pulses decoded from writes to CMD.
module dest_ip_tbl_axil_regs
   import dest_ip_tbl_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_TBL_ADDR_WIDTH   = 5
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr_i,
   input  logic                            awvalid_i,
   output logic                            awready_o,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_i,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb_i,
   input  logic                            wvalid_i,
   output logic                            wready_o,
   output logic                            bvalid_o,
   input  logic                            bready_i,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr_i,
   input  logic                            arvalid_i,
   output logic                            arready_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_o,
   output logic                            rvalid_o,
   input  logic                            rready_i,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_reg_i,
   input  logic [2:0]                      status_i,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   hits_i,
   output logic [C_TBL_ADDR_WIDTH-1:0]     idx_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_reg_o,
   output logic                            cmd_wr_o,
   output logic                            cmd_rd_o
);

   logic                          awready_q, arready_q, bvalid_q, rvalid_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, wdata_q, rd_mux;
   logic [C_TBL_ADDR_WIDTH-1:0]   idx_q;
   logic [2:0]                    wr_sel, rd_sel;
   logic                          wr_en, rd_en, cmd_hit;
   logic                          unused_addr;

   assign wr_sel  = awaddr_i[4:2];
   assign rd_sel  = araddr_i[4:2];
   assign wr_en   = awready_q & awvalid_i & wvalid_i;
   assign rd_en   = arready_q & arvalid_i;
   assign cmd_hit = wr_en & (wr_sel == REG_CMD) & wstrb_i[0];

   assign cmd_wr_o    = cmd_hit & wdata_i[CMD_WR_BIT];
   assign cmd_rd_o    = cmd_hit & wdata_i[CMD_RD_BIT];
   assign awready_o   = awready_q;
   assign wready_o    = awready_q;
   assign bvalid_o    = bvalid_q;
   assign arready_o   = arready_q;
   assign rvalid_o    = rvalid_q;
   assign rdata_o     = rdata_q;
   assign idx_o       = idx_q;
   assign wdata_reg_o = wdata_q;
   assign unused_addr = ^{awaddr_i[C_S_AXI_ADDR_WIDTH-1:5], awaddr_i[1:0],
                          araddr_i[C_S_AXI_ADDR_WIDTH-1:5], araddr_i[1:0]};

   always_comb begin
      rd_mux = '0;
      case (rd_sel)
         REG_IDX:    rd_mux[C_TBL_ADDR_WIDTH-1:0] = idx_q;
         REG_WDATA:  rd_mux = wdata_q;
         REG_RDATA:  rd_mux = rdata_reg_i;
         REG_STATUS: rd_mux[2:0] = status_i;
         REG_HITS:   rd_mux = hits_i;
         default:    rd_mux = '0;
      endcase
   end

   // The read mux samples registers before this edge's write lands, so a
   // simultaneous read sees the pre-write value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         awready_q <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         idx_q     <= '0;
         wdata_q   <= '0;
      end else begin
         awready_q <= awvalid_i & wvalid_i & ~bvalid_q & ~awready_q;
         arready_q <= arvalid_i & ~rvalid_q & ~arready_q;
         if (wr_en)         bvalid_q <= 1'b1;
         else if (bready_i) bvalid_q <= 1'b0;
         if (rd_en) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
         end else if (rready_i) begin
            rvalid_q <= 1'b0;
         end
         if (wr_en && wr_sel == REG_IDX && wstrb_i[0])
            idx_q <= wdata_i[C_TBL_ADDR_WIDTH-1:0];
         if (wr_en && wr_sel == REG_WDATA)
            for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++)
               if (wstrb_i[b]) wdata_q[8*b +: 8] <= wdata_i[8*b +: 8];
      end
   end

endmodule

// File: rtl/dest_ip_tbl_ctrl.sv
// Host-side controller for the destination-IP table port. Optional ack timeout
// is enabled with `define DEST_IP_TBL_TIMEOUT_EN.
//   state   | meaning
//   IDLE    | no operation in flight, accepts CMD
//   WR_REQ  | tbl_wr_req pulse with latched index/data
//   WR_WAIT | waiting for tbl_wr_ack
//   RD_REQ  | tbl_rd_req pulse with latched index
//   RD_WAIT | waiting for tbl_rd_ack, captures tbl_rd_data
module dest_ip_tbl_ctrl
   import dest_ip_tbl_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_TBL_ADDR_WIDTH   = 5,
   parameter int C_ACK_TIMEOUT      = 16
) (
   input  logic                            AXI_ACLK,
   input  logic                            reset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            tbl_wr_req,
   output logic                            tbl_rd_req,
   output logic [C_TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
   output logic [C_TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   tbl_wr_data,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   tbl_rd_data,
   input  logic                            tbl_wr_ack,
   input  logic                            tbl_rd_ack,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   dest_hit_count
);

   tbl_state_e                    state_q, state_d;
   logic                          done_q, done_d, err_q, err_d;
   logic                          launch, rd_capture, tmo_hit, busy;
   logic                          cmd_wr, cmd_rd;
   logic [C_TBL_ADDR_WIDTH-1:0]   idx, addr_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] wdata_reg, data_q, rdata_reg_q;
   logic [2:0]                    status;

   assign busy = (state_q != IDLE);
   always_comb begin
      status                = '0;
      status[STAT_BUSY_BIT] = busy;
      status[STAT_DONE_BIT] = done_q;
      status[STAT_ERR_BIT]  = err_q;
   end

   dest_ip_tbl_axil_regs #(
      .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
      .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
      .C_TBL_ADDR_WIDTH   (C_TBL_ADDR_WIDTH)
   ) u_regs (
      .clk_i       (AXI_ACLK),
      .rst_i       (reset),
      .awaddr_i    (S_AXI_AWADDR),
      .awvalid_i   (S_AXI_AWVALID),
      .awready_o   (S_AXI_AWREADY),
      .wdata_i     (S_AXI_WDATA),
      .wstrb_i     (S_AXI_WSTRB),
      .wvalid_i    (S_AXI_WVALID),
      .wready_o    (S_AXI_WREADY),
      .bvalid_o    (S_AXI_BVALID),
      .bready_i    (S_AXI_BREADY),
      .araddr_i    (S_AXI_ARADDR),
      .arvalid_i   (S_AXI_ARVALID),
      .arready_o   (S_AXI_ARREADY),
      .rdata_o     (S_AXI_RDATA),
      .rvalid_o    (S_AXI_RVALID),
      .rready_i    (S_AXI_RREADY),
      .rdata_reg_i (rdata_reg_q),
      .status_i    (status),
      .hits_i      (dest_hit_count),
      .idx_o       (idx),
      .wdata_reg_o (wdata_reg),
      .cmd_wr_o    (cmd_wr),
      .cmd_rd_o    (cmd_rd)
   );

   assign S_AXI_BRESP = 2'b00;
   assign S_AXI_RRESP = 2'b00;
   assign tbl_wr_req  = (state_q == WR_REQ) & ~reset;
   assign tbl_rd_req  = (state_q == RD_REQ) & ~reset;
   assign tbl_wr_addr = addr_q;
   assign tbl_rd_addr = addr_q;
   assign tbl_wr_data = data_q;

`ifdef DEST_IP_TBL_TIMEOUT_EN
   localparam int TMO_W = $clog2(C_ACK_TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt_q;
   logic             in_wait;

   assign in_wait = (state_q == WR_WAIT) || (state_q == RD_WAIT);
   assign tmo_hit = in_wait && (tmo_cnt_q == TMO_W'(C_ACK_TIMEOUT - 1));

   always_ff @(posedge AXI_ACLK) begin
      if (reset || !in_wait) tmo_cnt_q <= '0;
      else                   tmo_cnt_q <= tmo_cnt_q + 1'b1;
   end
`else
   logic unused_tmo;
   assign tmo_hit    = 1'b0;
   assign unused_tmo = (C_ACK_TIMEOUT > 0);
`endif

   always_comb begin
      state_d    = state_q;
      done_d     = done_q;
      err_d      = err_q;
      launch     = 1'b0;
      rd_capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_wr) begin
               state_d = WR_REQ;
               launch  = 1'b1;
            end else if (cmd_rd) begin
               state_d = RD_REQ;
               launch  = 1'b1;
            end
            if (launch) begin
               done_d = 1'b0;
               err_d  = 1'b0;
            end
         end
         WR_REQ: state_d = WR_WAIT;
         RD_REQ: state_d = RD_WAIT;
         WR_WAIT: begin
            if (tbl_wr_ack) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (tmo_hit) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         RD_WAIT: begin
            if (tbl_rd_ack) begin
               state_d    = IDLE;
               done_d     = 1'b1;
               rd_capture = 1'b1;
            end else if (tmo_hit) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge AXI_ACLK) begin
      if (reset) begin
         state_q     <= IDLE;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         rdata_reg_q <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         err_q   <= err_d;
         if (launch) begin
            addr_q <= idx;
            data_q <= wdata_reg;
         end
         if (rd_capture) rdata_reg_q <= tbl_rd_data;
      end
   end

endmodule

// File: doc/dest_ip_tbl_ctrl.md
Name: dest_ip_tbl_ctrl

Overview:
- AXI4-Lite register slave that acts as the initiator/host side of the destination-IP table access port (tbl_*_req / tbl_*_ack handshake) on the router output-port-lookup path.
- Software writes an index and data, then triggers a command.
- An FSM issues a one-cycle request pulse, waits for the responder's ack and captures read data into a readable register.
- Also exposes the responder's dest_hit_count.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width and table entry width.
- C_S_AXI_ADDR_WIDTH, 32, AXI-Lite address width; only bits [4:2] decoded.
- C_TBL_ADDR_WIDTH, 5, table index width (32 entries).
- C_ACK_TIMEOUT, 16, cycles to wait for ack before abort (used only with the optional feature).

Ports:
- AXI_ACLK  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
- S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  always OKAY (2'b00).
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  always OKAY.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake.
- tbl_wr_req  out  1  write request pulse.
- tbl_rd_req  out  1  read request pulse.
- tbl_wr_addr  out  C_TBL_ADDR_WIDTH  write index.
- tbl_rd_addr  out  C_TBL_ADDR_WIDTH  read index.
- tbl_wr_data  out  C_S_AXI_DATA_WIDTH  write value.
- tbl_rd_data  in  C_S_AXI_DATA_WIDTH  value returned by the responder.
- tbl_wr_ack  in  1  write ack pulse.
- tbl_rd_ack  in  1  read ack pulse; tbl_rd_data is valid in the same cycle.
- dest_hit_count  in  C_S_AXI_DATA_WIDTH  hit counter from the responder.

Behaviour:
- Register map (byte offset):
  - 0x00 IDX (RW), bits [4:0].
  - 0x04 WDATA (RW).
  - 0x08 RDATA (RO).
  - 0x0C CMD (WO): bit0 = write trigger, bit1 = read trigger; read-back returns 0.
  - 0x10 STATUS (RO): bit0 busy, bit1 done (sticky), bit2 timeout error (sticky).
  - 0x14 HITS (RO): live dest_hit_count.
  - Unmapped reads return 0; unmapped writes are ignored. All responses are OKAY.
- Write channel:
  - AWREADY and WREADY assert together for one cycle only when AWVALID & WVALID & !BVALID.
  - BVALID is set on the following cycle and held until BREADY.
  - WSTRB applies per byte to IDX and WDATA. CMD acts if byte 0 is strobed.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID & !RVALID.
  - RDATA/RVALID are registered one cycle later and held until RREADY.
- If an AXI write and an AXI read are accepted in the same cycle, both complete independently; register reads see the pre-write value.
- FSM states and transitions:
  - IDLE -> WR_REQ on CMD bit0. If bits 0 and 1 are both set, write wins.
  - IDLE -> RD_REQ on CMD bit1.
  - WR_REQ: tbl_wr_req=1 for exactly one cycle -> WR_WAIT.
  - WR_WAIT: on tbl_wr_ack -> IDLE, done=1.
  - RD_REQ: tbl_rd_req=1 for exactly one cycle -> RD_WAIT.
  - RD_WAIT: on tbl_rd_ack -> capture tbl_rd_data into RDATA, -> IDLE, done=1.
- Busy = state != IDLE. A CMD write while busy is ignored and its AXI response is still OKAY.
- A CMD write accepted in IDLE clears done and error in the same cycle the command is launched.
- tbl_wr_addr and tbl_rd_addr are driven from IDX; tbl_wr_data from WDATA.
  - IDX and WDATA writes while busy are accepted. The values are already latched into separate launch registers at CMD time, so an in-flight operation is unaffected.
- Acks received in IDLE or in the wrong WAIT state are ignored.
- Latency: CMD accepted (cycle N) -> req at N+1 -> responder ack at N+2 -> STATUS.done visible to a read issued at N+3.
- Reset values:
  - All req outputs 0; AWREADY, WREADY, BVALID, ARREADY, RVALID 0.
  - RDATA, S_AXI_RDATA, IDX, WDATA 0; STATUS 0; state IDLE.
- Reset mid-operation: FSM returns to IDLE, req drops immediately, pending AXI responses are discarded, and a late ack is ignored.

Optional Feature:
- Macro DEST_IP_TBL_TIMEOUT_EN.
- Defined: an up-counter runs in WR_WAIT/RD_WAIT. If C_ACK_TIMEOUT cycles pass without the matching ack, the FSM -> IDLE, STATUS.error=1 and done stays 0; RDATA is unchanged on a read timeout.
- Undefined: no counter; the WAIT states wait indefinitely and STATUS bit2 reads 0.

Decomposition:
- Package dest_ip_tbl_pkg: register offset constants, CMD/STATUS bit positions, FSM state enum (IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT).
- One natural sub-module, dest_ip_tbl_axil_regs: the AXI-Lite handshake and register decode, emitting cmd_wr/cmd_rd pulses. The FSM and launch registers stay in the top.

Test Plan:
- Write IDX=5, WDATA=0xC0A80001, CMD=0x1 -> one-cycle tbl_wr_req with tbl_wr_addr=5, tbl_wr_data=0xC0A80001; after ack, STATUS=0x2.
- IDX=5, CMD=0x2, responder returns 0xC0A80001 with ack -> exactly one tbl_rd_req pulse; RDATA reads 0xC0A80001; STATUS=0x2.
- CMD=0x3 -> only a write is issued. A second CMD while busy produces no extra req pulse; BRESP is OKAY.
- Hold BREADY/RREADY low for 10 cycles -> BVALID/RVALID stay high with stable data; no new AW/AR is accepted until the response is taken.
- Assert reset during RD_WAIT, then pulse tbl_rd_ack -> after reset STATUS=0 and RDATA=0; the stray ack is ignored.
- With DEST_IP_TBL_TIMEOUT_EN and a silent responder -> after 16 cycles STATUS=0x4; the next CMD clears it and proceeds normally.
